// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline skid stage.
// Latency: none (declarations only).
// Backpressure: not applicable.
package pipe_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int STALL_CNT_W = 32;

    typedef logic [DEF_WIDTH-1:0] lane_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready bundle link into and out of one pipeline stage.
// Latency: none (wiring only).
// Backpressure: in_ready/out_ready carry the stall in each direction.
interface pipe_stage_skid_if #(
    parameter int LANES = 2,
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [LANES-1:0] in_lane_vld;
    logic [WIDTH-1:0] in_data [LANES-1:0];
    logic             out_valid;
    logic             out_ready;
    logic [LANES-1:0] out_lane_vld;
    logic [WIDTH-1:0] out_data [LANES-1:0];

    modport master (
        output in_valid, in_lane_vld, in_data, out_ready,
        input  in_ready, out_valid, out_lane_vld, out_data
    );

    modport slave (
        input  in_valid, in_lane_vld, in_data, out_ready,
        output in_ready, out_valid, out_lane_vld, out_data
    );
endinterface

// File: rtl/pipe_skid_ctrl.sv
// Occupancy FSM for the two-entry skid stage; emits register load strobes.
// Latency: handshake outputs are decoded from state only (registered).
// Backpressure: in_ready drops only when both entries are held.
module pipe_skid_ctrl
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    input  logic        out_ready,
    output skid_state_t state,
    output logic        in_ready,
    output logic        out_valid,
    output logic        load_main,
    output logic        load_skid,
    output logic        skid_to_main
);
    skid_state_t state_q, state_d;
    logic        in_fire, out_fire;

    assign in_fire  = in_valid & (state_q != FULL);
    assign out_fire = out_ready & (state_q != EMPTY);

    always_ff @(posedge clk) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY:   if (in_fire) state_d = BUSY;
                BUSY: begin
                    if (in_fire && !out_fire)      state_d = FULL;
                    else if (!in_fire && out_fire) state_d = EMPTY;
                end
                FULL:    if (out_fire) state_d = BUSY;
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        state        = state_q;
        in_ready     = (state_q != FULL);
        out_valid    = (state_q != EMPTY);
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        if (!flush) begin
            // Main refills from input when it is empty or draining this cycle.
            load_main    = in_fire & ((state_q == EMPTY) | ((state_q == BUSY) & out_fire));
            load_skid    = in_fire & (state_q == BUSY) & ~out_fire;
            skid_to_main = (state_q == FULL) & out_fire;
        end
    end
endmodule

// File: rtl/pipe_stage_skid.sv
// N-lane pipeline register with 2-entry skid and flush; PIPE_STAGE_STATS_EN adds stall_cnt.
// Latency: 1 cycle, 1 bundle/cycle sustained.
// Backpressure: in_ready is registered (state != FULL); no comb ready path.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int LANES = 2,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    pipe_stage_skid_if.slave       bus,
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    skid_state_t      state;
    logic             out_valid;
    logic             load_main, load_skid, skid_to_main;
    logic [LANES-1:0] main_vld, skid_vld;
    logic [WIDTH-1:0] main_dat [LANES-1:0];
    logic [WIDTH-1:0] skid_dat [LANES-1:0];
    logic             main_from_skid;

    pipe_skid_ctrl u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (bus.in_valid),
        .out_ready    (bus.out_ready),
        .state        (state),
        .in_ready     (bus.in_ready),
        .out_valid    (out_valid),
        .load_main    (load_main),
        .load_skid    (load_skid),
        .skid_to_main (skid_to_main)
    );

    assign main_from_skid = (state == FULL);

    // Flush clears only the lane masks; data is don't-care while out_valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_vld <= '0;
            skid_vld <= '0;
            for (int i = 0; i < LANES; i++) begin
                main_dat[i] <= '0;
                skid_dat[i] <= '0;
            end
        end else if (flush) begin
            main_vld <= '0;
            skid_vld <= '0;
        end else begin
            if (load_main || skid_to_main) begin
                main_vld <= main_from_skid ? skid_vld : bus.in_lane_vld;
                for (int i = 0; i < LANES; i++)
                    main_dat[i] <= main_from_skid ? skid_dat[i] : bus.in_data[i];
            end
            if (load_skid) begin
                skid_vld <= bus.in_lane_vld;
                for (int i = 0; i < LANES; i++)
                    skid_dat[i] <= bus.in_data[i];
            end
        end
    end

    assign bus.out_valid    = out_valid;
    assign bus.out_lane_vld = main_vld;
    assign bus.out_data     = main_dat;

`ifdef PIPE_STAGE_STATS_EN
    logic [STALL_CNT_W-1:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst)
            stall_q <= '0;
        else if (out_valid && !bus.out_ready && (stall_q != {STALL_CNT_W{1'b1}}))
            stall_q <= stall_q + 1'b1;
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: reset, streaming, skid, flush, bubble, stats.
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   flush;
    logic [STALL_CNT_W-1:0] stall_cnt;
    int                     tests = 0;
    int                     fails = 0;

    pipe_stage_skid_if #(.LANES(2), .WIDTH(32)) bus_i ();

    pipe_stage_skid #(.LANES(2), .WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus_i),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] lv, input lane_t d0, input lane_t d1);
        bus_i.in_valid    = v;
        bus_i.in_lane_vld = lv;
        bus_i.in_data[0]  = d0;
        bus_i.in_data[1]  = d1;
    endtask

    // Expected stall count in the stats build; zero otherwise.
    function automatic logic [31:0] stall_exp(input logic [31:0] n);
`ifdef PIPE_STAGE_STATS_EN
        return n;
`else
        return 32'd0 & n;
`endif
    endfunction

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        bus_i.out_ready = 1'b0;
        drive(1'b1, 2'b11, 32'h55, 32'h66);
        step();
        step();
        chk("rst_out_valid", {31'd0, bus_i.out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, bus_i.in_ready}, 32'd1);
        chk("rst_lane_vld", {30'd0, bus_i.out_lane_vld}, 32'd0);
        chk("rst_data0", bus_i.out_data[0], 32'd0);
        chk("rst_data1", bus_i.out_data[1], 32'd0);
        chk("rst_stall", stall_cnt, 32'd0);

        // Back-to-back streaming
        rst = 1'b0;
        bus_i.out_ready = 1'b1;
        drive(1'b1, 2'b11, 32'h1, 32'h2);
        step();
        chk("s1_valid", {31'd0, bus_i.out_valid}, 32'd1);
        chk("s1_d0", bus_i.out_data[0], 32'h1);
        chk("s1_d1", bus_i.out_data[1], 32'h2);
        chk("s1_in_ready", {31'd0, bus_i.in_ready}, 32'd1);
        drive(1'b1, 2'b11, 32'h3, 32'h4);
        step();
        chk("s2_d0", bus_i.out_data[0], 32'h3);
        chk("s2_d1", bus_i.out_data[1], 32'h4);
        chk("s2_in_ready", {31'd0, bus_i.in_ready}, 32'd1);
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        step();
        chk("s3_empty", {31'd0, bus_i.out_valid}, 32'd0);

        // Skid: A held, B arrives under stall
        drive(1'b1, 2'b11, 32'hA0, 32'hA1);
        step();
        bus_i.out_ready = 1'b0;
        drive(1'b1, 2'b01, 32'hB0, 32'hB1);
        step();
        chk("full_in_ready", {31'd0, bus_i.in_ready}, 32'd0);
        chk("full_valid", {31'd0, bus_i.out_valid}, 32'd1);
        chk("full_data_a", bus_i.out_data[0], 32'hA0);
        chk("full_stall", stall_cnt, stall_exp(32'd1));
        bus_i.out_ready = 1'b1;
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        step();
        chk("drain_b0", bus_i.out_data[0], 32'hB0);
        chk("drain_b1", bus_i.out_data[1], 32'hB1);
        chk("drain_b_lv", {30'd0, bus_i.out_lane_vld}, 32'h1);
        chk("drain_in_ready", {31'd0, bus_i.in_ready}, 32'd1);
        step();
        chk("drain_empty", {31'd0, bus_i.out_valid}, 32'd0);

        // Flush while FULL with C presented
        bus_i.out_ready = 1'b0;
        drive(1'b1, 2'b11, 32'hA0, 32'hA1);
        step();
        drive(1'b1, 2'b11, 32'hB0, 32'hB1);
        step();
        chk("f_full", {31'd0, bus_i.in_ready}, 32'd0);
        drive(1'b1, 2'b11, 32'hC0, 32'hC1);
        flush = 1'b1;
        step();
        chk("f_valid", {31'd0, bus_i.out_valid}, 32'd0);
        chk("f_lane_vld", {30'd0, bus_i.out_lane_vld}, 32'd0);
        chk("f_in_ready", {31'd0, bus_i.in_ready}, 32'd1);
        flush = 1'b0;
        bus_i.out_ready = 1'b1;
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        step();
        chk("f_stays_empty", {31'd0, bus_i.out_valid}, 32'd0);

        // Flush in BUSY while an incoming bundle fires
        drive(1'b1, 2'b11, 32'hD0, 32'hD1);
        step();
        drive(1'b1, 2'b11, 32'hE0, 32'hE1);
        flush = 1'b1;
        step();
        chk("fb_valid", {31'd0, bus_i.out_valid}, 32'd0);
        flush = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        step();
        chk("fb_no_e", {31'd0, bus_i.out_valid}, 32'd0);

        // Bubble bundle
        drive(1'b1, 2'b00, 32'h7, 32'h8);
        step();
        chk("bub_valid", {31'd0, bus_i.out_valid}, 32'd1);
        chk("bub_lane_vld", {30'd0, bus_i.out_lane_vld}, 32'd0);
        chk("bub_d0", bus_i.out_data[0], 32'h7);
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        step();
        chk("bub_gone", {31'd0, bus_i.out_valid}, 32'd0);

        // Reset while holding a bundle
        bus_i.out_ready = 1'b0;
        drive(1'b1, 2'b11, 32'hF0, 32'hF1);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_valid", {31'd0, bus_i.out_valid}, 32'd0);
        chk("mrst_in_ready", {31'd0, bus_i.in_ready}, 32'd1);
        chk("mrst_stall", stall_cnt, 32'd0);

        // Stall statistics
        bus_i.out_ready = 1'b1;
        drive(1'b1, 2'b10, 32'h11, 32'h22);
        step();
        bus_i.out_ready = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        repeat (5) step();
        chk("st_held_d1", bus_i.out_data[1], 32'h22);
        chk("st_cnt5", stall_cnt, stall_exp(32'd5));
        bus_i.out_ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("st_flush_valid", {31'd0, bus_i.out_valid}, 32'd0);
        chk("st_flush_keep", stall_cnt, stall_exp(32'd5));
        step();
        chk("st_flush_keep2", stall_cnt, stall_exp(32'd5));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("st_rst_clear", stall_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
